dac_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single serial DAC among the N_CHAN output channels. It sits between the per-channel output post-processors, which produce `opp_dac_data` and `opp_dac_data_valid`, and the DAC serial driver. It holds the newest pending code for each channel and issues one 32-bit DAC write instruction at a time. It waits for the driver's completion pulse before issuing the next instruction.

---
 rtl/dac_write_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dac_write_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_arbiter.sv
// Round-robin arbiter sharing one serial DAC between N_CHAN output channels.
// Optional WAIT timeout abort is enabled with the DAC_ARB_TIMEOUT_EN macro.
module dac_write_arbiter #(
    parameter int N_CHAN         = 8,
    parameter int W_DATA         = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [N_CHAN-1:0]        data_valid_in,
    input  logic [N_CHAN*W_DATA-1:0] data_in,
    input  logic                     dac_done_in,
    output logic [31:0]              dac_instr_out,
    output logic                     dac_instr_valid_out,
    output logic [3:0]               grant_out,
    output logic [N_CHAN-1:0]        pending_out,
    output logic                     overrun_out
`ifdef DAC_ARB_TIMEOUT_EN
    ,
    output logic                     timeout_out
`endif
);

    localparam int W_EXT = (W_DATA > 16) ? W_DATA : 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [31:0]             instr_q;
    logic                    instr_valid_q;
    logic [3:0]              grant_q;
    logic [N_CHAN-1:0]       pending_q;
    logic [N_CHAN-1:0]       pending_d;
    logic [W_DATA-1:0]       code_q [N_CHAN];
    logic [W_DATA-1:0]       code_d [N_CHAN];
    logic                    overrun_q;
    logic                    overrun_s;
    logic [4:0]              pick_s;
    logic                    sel_found_s;
    logic [3:0]              sel_idx_s;
    logic [W_DATA-1:0]       sel_code_s;
    logic                    grant_now_s;
    logic [N_CHAN-1:0]       grant_mask_s;

`ifdef DAC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        wait_cnt_q;
    logic                    timeout_q;
`endif

    // Fit a channel code into the 16-bit data field (zero-extend or truncate).
    function automatic logic [15:0] to_code16(input logic [W_DATA-1:0] code);
        logic [W_EXT-1:0] ext;
        ext = W_EXT'(code);
        return ext[15:0];
    endfunction

    // First pending channel after 'last', wrapping; returns {found, index}.
    function automatic logic [4:0] rr_pick(input logic [N_CHAN-1:0] pend,
                                           input logic [3:0]        last);
        logic [4:0] res;
        int         idx;
        res = 5'd0;
        for (int i = N_CHAN; i >= 1; i--) begin
            idx = (int'(last) + i) % N_CHAN;
            if (pend[idx]) begin
                res = {1'b1, 4'(idx)};
            end
        end
        return res;
    endfunction

    // Arbitration decision and per-channel next-state for codes and pending flags.
    always_comb begin
        pick_s      = rr_pick(pending_q, grant_q);
        sel_found_s = pick_s[4];
        sel_idx_s   = pick_s[3:0];
        grant_now_s = (state_q == ST_IDLE) && sel_found_s;
        sel_code_s  = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            sel_code_s = (sel_idx_s == 4'(k)) ? code_q[k] : sel_code_s;
            grant_mask_s[k] = grant_now_s && (sel_idx_s == 4'(k));
            // A same-edge valid re-arms the flag, so clear first and set second.
            pending_d[k] = data_valid_in[k] | (pending_q[k] & ~grant_mask_s[k]);
            code_d[k]    = data_valid_in[k] ? data_in[k*W_DATA +: W_DATA] : code_q[k];
        end
        overrun_s = |(data_valid_in & pending_q & ~grant_mask_s);
    end

    // Per-channel code store, pending flags and overrun pulse.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            pending_q <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < N_CHAN; k++) begin
                code_q[k] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_s;
            for (int k = 0; k < N_CHAN; k++) begin
                code_q[k] <= code_d[k];
            end
        end
    end

    // Issue FSM with registered instruction, strobe and grant index.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q       <= ST_IDLE;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            grant_q       <= 4'(N_CHAN - 1);
`ifdef DAC_ARB_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_now_s) begin
                        instr_q       <= {4'h0, 4'h3, sel_idx_s, to_code16(sel_code_s), 4'h0};
                        instr_valid_q <= 1'b1;
                        grant_q       <= sel_idx_s;
                        state_q       <= ST_ISSUE;
                    end else begin
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    instr_valid_q <= 1'b0;
                    state_q       <= ST_WAIT;
`ifdef DAC_ARB_TIMEOUT_EN
                    wait_cnt_q    <= '0;
`endif
                end
                ST_WAIT: begin
                    instr_valid_q <= 1'b0;
                    if (dac_done_in) begin
                        state_q <= ST_IDLE;
`ifdef DAC_ARB_TIMEOUT_EN
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abandon the frame; the granted channel is not re-queued.
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                        state_q    <= ST_WAIT;
`else
                    end else begin
                        state_q <= ST_WAIT;
`endif
                    end
                end
                default: begin
                    instr_valid_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign dac_instr_out       = instr_q;
    assign dac_instr_valid_out = instr_valid_q;
    assign grant_out           = grant_q;
    assign pending_out         = pending_q;
    assign overrun_out         = overrun_q;
`ifdef DAC_ARB_TIMEOUT_EN
    assign timeout_out         = timeout_q;
`endif

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Self-checking bench for dac_write_arbiter: directed scenarios plus random
// traffic compared cycle by cycle against a transaction-level reference model.
module tb_dac_write_arbiter;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int TO = 16;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic [N-1:0]   data_valid_in;
    logic [N*W-1:0] data_in;
    logic           dac_done_in;
    logic [31:0]    dac_instr_out;
    logic           dac_instr_valid_out;
    logic [3:0]     grant_out;
    logic [N-1:0]   pending_out;
    logic           overrun_out;
`ifdef DAC_ARB_TIMEOUT_EN
    logic           timeout_out;
`endif

    dac_write_arbiter #(.N_CHAN(N), .W_DATA(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in              (clk_in),
        .reset_in            (reset_in),
        .data_valid_in       (data_valid_in),
        .data_in             (data_in),
        .dac_done_in         (dac_done_in),
        .dac_instr_out       (dac_instr_out),
        .dac_instr_valid_out (dac_instr_valid_out),
        .grant_out           (grant_out),
        .pending_out         (pending_out),
        .overrun_out         (overrun_out)
`ifdef DAC_ARB_TIMEOUT_EN
        ,
        .timeout_out         (timeout_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    // Reference model: pending codes, last served channel, driver busy flag.
    logic [N-1:0]   m_pend;
    logic [W-1:0]   m_code [N];
    int             m_last;
    bit             m_free;
    int             m_wcnt;
    bit             m_tout;
    logic           e_valid;
    logic [31:0]    e_instr;
    logic           e_ovr;
    int             since_issue;
    int             issues;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("instr_valid", 32'(dac_instr_valid_out), 32'(e_valid));
        chk("instr", dac_instr_out, e_instr);
        chk("grant", 32'(grant_out), 32'(m_last));
        chk("pending", 32'(pending_out), 32'(m_pend));
        chk("overrun", 32'(overrun_out), 32'(e_ovr));
`ifdef DAC_ARB_TIMEOUT_EN
        chk("timeout", 32'(timeout_out), 32'(m_tout));
`endif
    endtask

    task automatic model_reset();
        m_pend  = '0;
        for (int k = 0; k < N; k++) m_code[k] = '0;
        m_last  = N - 1;
        m_free  = 1'b1;
        m_wcnt  = 0;
        m_tout  = 1'b0;
        e_valid = 1'b0;
        e_instr = 32'h0;
        e_ovr   = 1'b0;
        since_issue = 0;
    endtask

    // Predict DUT outputs after the coming rising edge, given the driven inputs.
    task automatic model_step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic done);
        logic [N-1:0] gmask;
        bit           in_issue;
        bit           was_free;
        int           g;
        gmask    = '0;
        in_issue = e_valid;
        was_free = m_free;
        e_valid  = 1'b0;
        if (was_free && m_pend != '0) begin
            g = -1;
            for (int i = 1; i <= N; i++) begin
                if (g < 0 && m_pend[(m_last + i) % N]) g = (m_last + i) % N;
            end
            e_instr  = {4'h0, 4'h3, 4'(g), m_code[g], 4'h0};
            e_valid  = 1'b1;
            m_last   = g;
            m_free   = 1'b0;
            m_wcnt   = 0;
            gmask[g] = 1'b1;
            issues++;
            since_issue = 0;
        end else begin
            since_issue++;
            if (!was_free && !in_issue) begin
                if (done) begin
                    m_free = 1'b1;
                end else begin
`ifdef DAC_ARB_TIMEOUT_EN
                    m_wcnt++;
                    if (m_wcnt == TO) begin
                        m_free = 1'b1;
                        m_tout = 1'b1;
                    end
`endif
                end
            end
        end
        e_ovr  = |(v & m_pend & ~gmask);
        m_pend = (m_pend & ~gmask) | v;
        for (int k = 0; k < N; k++) begin
            if (v[k]) m_code[k] = d[k*W +: W];
        end
    endtask

    task automatic tick(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic done);
        @(negedge clk_in);
        check_all();
        data_valid_in = v;
        data_in       = d;
        dac_done_in   = done;
        model_step(v, d, done);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        data_valid_in = '0;
        data_in       = '0;
        dac_done_in   = 1'b0;
        reset_in      = 1'b1;
        model_reset();
        @(negedge clk_in);
        check_all();
        reset_in = 1'b0;
    endtask

    function automatic logic [N*W-1:0] one(input int ch, input logic [W-1:0] c);
        logic [N*W-1:0] r;
        r = '0;
        r[ch*W +: W] = c;
        return r;
    endfunction

    initial begin
        logic [N*W-1:0] all_d;
        logic [N-1:0]   rv;
        logic [N*W-1:0] rd;
        int             base;
        issues        = 0;
        reset_in      = 1'b1;
        data_valid_in = '0;
        data_in       = '0;
        dac_done_in   = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk_in);
        reset_in = 1'b0;

        // Single request, driver done 50 cycles after the issue.
        base = issues;
        tick(8'h01, one(0, 16'd13107), 1'b0);
        for (int c = 0; c < 60; c++) tick('0, '0, since_issue == 50);
        chk("single_issues", 32'(issues - base), 32'd1);

        // All channels at once: served 0..7, done 20 cycles after each issue.
        do_reset();
        base = issues;
        for (int k = 0; k < N; k++) all_d[k*W +: W] = W'(100 + k);
        tick(8'hFF, all_d, 1'b0);
        for (int c = 0; c < 250; c++) tick('0, '0, since_issue == 20);
        chk("rr_issues", 32'(issues - base), 32'd8);

        // Overrun: channel 3 rewritten while channel 1 is in flight.
        base = issues;
        tick(8'h02, one(1, 16'h0055), 1'b0);
        tick('0, '0, 1'b0);
        tick(8'h08, one(3, 16'h1111), 1'b0);
        tick(8'h08, one(3, 16'h2222), 1'b0);
        for (int c = 0; c < 30; c++) tick('0, '0, since_issue == 6);
        chk("ovr_issues", 32'(issues - base), 32'd2);

        // Grant collision on channel 5.
        base = issues;
        tick(8'h20, one(5, 16'hAAAA), 1'b0);
        tick(8'h20, one(5, 16'hBEEF), 1'b0);
        chk("coll_first", e_instr, 32'h035AAAA0);
        for (int c = 0; c < 30; c++) tick('0, '0, since_issue == 4);
        chk("coll_issues", 32'(issues - base), 32'd2);
        chk("coll_second", e_instr, 32'h035BEEF0);

        // Reset while waiting with channels 1 and 2 pending.
        do_reset();
        tick(8'h01, one(0, 16'h0123), 1'b0);
        tick(8'h02, one(1, 16'h0456), 1'b0);
        tick(8'h04, one(2, 16'h0789), 1'b0);
        tick('0, '0, 1'b0);
        tick('0, '0, 1'b0);
        @(negedge clk_in);
        check_all();
        data_valid_in = '0;
        #2 reset_in = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk_in);
        reset_in = 1'b0;
        base = issues;
        for (int c = 0; c < 12; c++) tick('0, '0, (c % 3) == 0);
        chk("post_reset_issues", 32'(issues - base), 32'd0);

`ifdef DAC_ARB_TIMEOUT_EN
        // Done never arrives: timeout, then the next pending channel goes out.
        tick(8'h41, one(0, 16'h0AAA) | one(6, 16'h0BBB), 1'b0);
        for (int c = 0; c < 2 * TO + 10; c++) tick('0, '0, 1'b0);
        chk("timeout_flag", 32'(m_tout), 32'd1);
        do_reset();
`endif

        // Random traffic with random driver completion.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                rv[k]        = ($urandom_range(0, 9) == 0);
                rd[k*W +: W] = W'($urandom);
            end
            tick(rv, rd, $urandom_range(0, 5) == 0);
        end
        tick('0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
